tlb_tag_cam: RTL and testbench

- Fully-associative 8-entry tag CAM for the TLB; upstream of the 8x24 PFN/flags data RAM.
- Each lookup compares VPN+ASID against all entries combinationally. The result produces the data-RAM address (hit index), so translation finishes in the same cycle as the RAM's async read.
- Owns data-RAM write sequencing: indexed writes, random-replacement writes, and an invalidate-all sweep that zeroes every RAM row through the single write port.

---
 rtl/tlb_pkg.sv | 13 +
 rtl/tlb_rand_ctr.sv | 21 ++
 rtl/tlb_tag_cam.sv | 103 ++++++++++
 tb/tb_tlb_tag_cam.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// tlb_pkg: shared widths, FSM encoding and tag entry type for the TLB tag CAM
package tlb_pkg;
  localparam int ENTRIES = 8;
  localparam int IDX_W = 3;
  localparam int VPN_W = 20;
  localparam int ASID_W = 8;
  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} tlb_state_e;
  typedef struct packed {
    logic [VPN_W-1:0]  vpn;
    logic [ASID_W-1:0] asid;
    logic              g;
  } tlb_tag_t;
endpackage

// File: rtl/tlb_rand_ctr.sv
// tlb_rand_ctr: free-running random-replacement pointer, counts down and wraps above the wired floor
module tlb_rand_ctr
  import tlb_pkg::*;
#(
  parameter int WIRED = 0
) (
  input  logic             clk,
  input  logic             clrn,
  output logic [IDX_W-1:0] rand_idx
);
  localparam logic [IDX_W-1:0] TOP = IDX_W'(ENTRIES - 1);
  // A floor at or above the top entry collapses the counter into holding at the top.
  localparam logic [IDX_W-1:0] FLOOR = (WIRED >= ENTRIES - 1) ? TOP : IDX_W'(WIRED);
  logic [IDX_W-1:0] rand_q, rand_d;
  always_comb rand_d = (rand_q == FLOOR) ? TOP : rand_q - IDX_W'(1);
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) rand_q <= TOP;
    else       rand_q <= rand_d;
  end
  assign rand_idx = rand_q;
endmodule

// File: rtl/tlb_tag_cam.sv
// tlb_tag_cam: 8-entry fully-associative TLB tag CAM with data-RAM write sequencing.
// Define TLB_MULTIHIT_EN to add the multi_hit / sticky mh_err outputs.
module tlb_tag_cam
  import tlb_pkg::*;
#(
  parameter int WIRED = 0
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [VPN_W-1:0]  lk_vpn,
  input  logic [ASID_W-1:0] lk_asid,
  output logic              hit,
  output logic [IDX_W-1:0]  hit_idx,
  input  logic              wr_en,
  input  logic              wr_rand,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [VPN_W-1:0]  wr_vpn,
  input  logic [ASID_W-1:0] wr_asid,
  input  logic              wr_g,
  input  logic              inv_all,
  output logic              busy,
  output logic [IDX_W-1:0]  rand_idx,
  output logic [IDX_W-1:0]  ram_addr,
  output logic              ram_we,
  output logic              ram_clr
`ifdef TLB_MULTIHIT_EN
  ,
  output logic              multi_hit,
  output logic              mh_err
`endif
);
  tlb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [ENTRIES-1:0] valid_q, valid_d, match;
  tlb_tag_t         tag_q [ENTRIES];
  tlb_tag_t         tag_d [ENTRIES];
  logic [IDX_W-1:0] enc, tgt;
  logic             sweep, do_wr;
  tlb_rand_ctr #(.WIRED(WIRED)) u_rand (
    .clk      (clk),
    .clrn     (clrn),
    .rand_idx (rand_idx)
  );
  always_comb begin
    match = '0;
    for (int i = 0; i < ENTRIES; i++)
      match[i] = valid_q[i] && tag_q[i].vpn == lk_vpn && (tag_q[i].g || tag_q[i].asid == lk_asid);
  end
  // Scanning downward leaves the lowest matching index in enc.
  always_comb begin
    enc = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (match[i]) enc = IDX_W'(i);
  end
  assign sweep    = state_q == SWEEP;
  assign hit      = !sweep && |match;
  assign hit_idx  = hit ? enc : '0;
  assign do_wr    = !sweep && wr_en && !inv_all;
  assign tgt      = wr_rand ? rand_idx : wr_idx;
  assign busy     = sweep;
  assign ram_we   = sweep || do_wr;
  assign ram_clr  = sweep;
  assign ram_addr = sweep ? ptr_q : do_wr ? tgt : hit_idx;
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    if (sweep) begin
      valid_d[ptr_q] = 1'b0;
      ptr_d          = ptr_q + IDX_W'(1);
      state_d        = (ptr_q == IDX_W'(ENTRIES - 1)) ? IDLE : SWEEP;
    end else if (inv_all) begin
      state_d = SWEEP;
      ptr_d   = '0;
    end else if (wr_en) begin
      valid_d[tgt] = 1'b1;
      tag_d[tgt]   = tlb_tag_t'{vpn: wr_vpn, asid: wr_asid, g: wr_g};
    end
  end
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) tag_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
    end
  end
`ifdef TLB_MULTIHIT_EN
  logic mh_err_q;
  assign multi_hit = !sweep && |(match & (match - ENTRIES'(1)));
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) mh_err_q <= 1'b0;
    else       mh_err_q <= mh_err_q | multi_hit;
  end
  assign mh_err = mh_err_q;
`endif
endmodule

// File: tb/tb_tlb_tag_cam.sv
// tb_tlb_tag_cam: directed scoreboard bench for tlb_tag_cam (WIRED=0 and WIRED=4 instances)
module tb_tlb_tag_cam;
  logic clk = 1'b0;
  logic clrn = 1'b1;
  always #5 clk = ~clk;
  logic [19:0] lk_vpn = '0, wr_vpn = '0;
  logic [7:0]  lk_asid = '0, wr_asid = '0;
  logic        wr_en = 1'b0, wr_rand = 1'b0, wr_g = 1'b0, inv_all = 1'b0;
  logic [2:0]  wr_idx = '0;
  logic        hit0, busy0, we0, clr0, mh0, mhe0;
  logic [2:0]  hidx0, rnd0, ra0;
  logic        hit4, busy4, we4, clr4, mh4, mhe4;
  logic [2:0]  hidx4, rnd4, ra4;
  tlb_tag_cam #(.WIRED(0)) u_dut0 (
    .clk(clk), .clrn(clrn), .lk_vpn(lk_vpn), .lk_asid(lk_asid), .hit(hit0), .hit_idx(hidx0),
    .wr_en(wr_en), .wr_rand(wr_rand), .wr_idx(wr_idx), .wr_vpn(wr_vpn), .wr_asid(wr_asid),
    .wr_g(wr_g), .inv_all(inv_all), .busy(busy0), .rand_idx(rnd0), .ram_addr(ra0),
    .ram_we(we0), .ram_clr(clr0)
`ifdef TLB_MULTIHIT_EN
    , .multi_hit(mh0), .mh_err(mhe0)
`endif
  );
  tlb_tag_cam #(.WIRED(4)) u_dut4 (
    .clk(clk), .clrn(clrn), .lk_vpn(lk_vpn), .lk_asid(lk_asid), .hit(hit4), .hit_idx(hidx4),
    .wr_en(wr_en), .wr_rand(wr_rand), .wr_idx(wr_idx), .wr_vpn(wr_vpn), .wr_asid(wr_asid),
    .wr_g(wr_g), .inv_all(inv_all), .busy(busy4), .rand_idx(rnd4), .ram_addr(ra4),
    .ram_we(we4), .ram_clr(clr4)
`ifdef TLB_MULTIHIT_EN
    , .multi_hit(mh4), .mh_err(mhe4)
`endif
  );
`ifdef TLB_MULTIHIT_EN
  localparam logic [14:0] MM = 15'h7fff;
`else
  assign {mh0, mhe0, mh4, mhe4} = '0;
  localparam logic [14:0] MM = 15'h1fff;
`endif
  localparam logic [14:0] MR = 15'h00e0;
  localparam logic [14:0] MH = 15'h4000;
  logic [14:0] obs0, obs4;
  assign obs0 = {mh0, mhe0, hit0, hidx0, busy0, rnd0, ra0, we0, clr0};
  assign obs4 = {mh4, mhe4, hit4, hidx4, busy4, rnd4, ra4, we4, clr4};
  typedef struct {
    string       nm;
    bit          d4;
    logic [14:0] e;
    logic [14:0] m;
  } exp_t;
  exp_t q[$];
  int total = 0, passed = 0;
  logic [2:0] r0 = 3'd7, r4 = 3'd7;
  logic mhe_exp = 1'b0;
  int fill_idx[4] = '{0, 1, 4, 7};
  logic [2:0] last_t;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      logic [14:0] o;
      x = q.pop_front();
      o = x.d4 ? obs4 : obs0;
      total++;
      if ((o & x.m) !== (x.e & x.m))
        $display("FAIL %s (dut%0d): got %h expected %h mask %h", x.nm, x.d4 ? 4 : 0, o, x.e, x.m);
      else
        passed++;
    end
  end
  function automatic logic [14:0] mk(logic h, logic [2:0] hi, logic b, logic [2:0] r,
                                     logic [2:0] a, logic we, logic c);
    return {1'b0, mhe_exp, h, hi, b, r, a, we, c};
  endfunction
  task automatic cyc(string nm, bit d4, logic [14:0] e, logic [14:0] m);
    exp_t x;
    x.nm = nm; x.d4 = d4; x.e = e; x.m = m;
    q.push_back(x);
    @(posedge clk);
    #1;
    if (clrn) begin
      r0 = (r0 == 3'd0) ? 3'd7 : r0 - 3'd1;
      r4 = (r4 == 3'd4) ? 3'd7 : r4 - 3'd1;
    end
  endtask
  task automatic set_wr(logic e, logic r, logic [2:0] i, logic [19:0] v, logic [7:0] a, logic g);
    wr_en = e; wr_rand = r; wr_idx = i; wr_vpn = v; wr_asid = a; wr_g = g;
  endtask
  task automatic look(logic [19:0] v, logic [7:0] a);
    lk_vpn = v; lk_asid = a;
  endtask
  initial begin
    #1 clrn = 1'b0;
    @(posedge clk);
    #1;
    look(20'h12345, 8'h05);
    cyc("reset", 0, mk(0, 0, 0, 7, 0, 0, 0), MM);
    clrn = 1'b1;
    cyc("release", 0, mk(0, 0, 0, 7, 0, 0, 0), MM);
    for (int k = 0; k < 8; k++) cyc("rand_seq", 0, mk(0, 0, 0, 3'(6 - k), 0, 0, 0), MR);
    set_wr(1, 0, 3, 20'h12345, 8'h05, 0); look(20'h0, 8'h0);
    cyc("wr_idx3", 0, mk(0, 0, 0, r0, 3, 1, 0), MM);
    set_wr(0, 0, 0, 20'h0, 8'h0, 0); look(20'h12345, 8'h05);
    cyc("lk_hit3", 0, mk(1, 3, 0, r0, 3, 0, 0), MM);
    look(20'h12345, 8'h06);
    cyc("lk_asid_miss", 0, mk(0, 0, 0, r0, 0, 0, 0), MM);
    set_wr(1, 0, 3, 20'h11111, 8'h05, 0); look(20'h12345, 8'h05);
    cyc("wr_lk_same", 0, mk(1, 3, 0, r0, 3, 1, 0), MM);
    set_wr(0, 0, 0, 20'h0, 8'h0, 0);
    cyc("old_tag_gone", 0, mk(0, 0, 0, r0, 0, 0, 0), MM);
    look(20'h11111, 8'h05);
    cyc("new_tag_hit", 0, mk(1, 3, 0, r0, 3, 0, 0), MM);
    set_wr(1, 0, 5, 20'h0ABCD, 8'h33, 1); look(20'h0, 8'h0);
    cyc("wr_glob5", 0, mk(0, 0, 0, r0, 5, 1, 0), MM);
    set_wr(0, 0, 0, 20'h0, 8'h0, 0); look(20'h0ABCD, 8'h99);
    cyc("glob_hit_a", 0, mk(1, 5, 0, r0, 5, 0, 0), MM);
    look(20'h0ABCD, 8'h00);
    cyc("glob_hit_b", 0, mk(1, 5, 0, r0, 5, 0, 0), MM);
    set_wr(1, 0, 6, 20'h77777, 8'h01, 0); look(20'h0, 8'h0);
    cyc("wr_dup6", 0, mk(0, 0, 0, r0, 6, 1, 0), MM);
    set_wr(1, 0, 2, 20'h77777, 8'h01, 0);
    cyc("wr_dup2", 0, mk(0, 0, 0, r0, 2, 1, 0), MM);
    set_wr(0, 0, 0, 20'h0, 8'h0, 0); look(20'h77777, 8'h01);
    cyc("dup_lowest", 0, mk(1, 2, 0, r0, 2, 0, 0) | MH, MM);
    mhe_exp = 1'b1;
    set_wr(1, 0, 6, 20'h00001, 8'h01, 0);
    cyc("ovw6", 0, mk(1, 2, 0, r0, 6, 1, 0) | MH, MM);
    set_wr(1, 0, 2, 20'h00002, 8'h01, 0);
    cyc("ovw2", 0, mk(1, 2, 0, r0, 2, 1, 0), MM);
    set_wr(0, 0, 0, 20'h0, 8'h0, 0);
    cyc("mh_sticky", 0, mk(0, 0, 0, r0, 0, 0, 0), MM);
    look(20'h0, 8'h0);
    foreach (fill_idx[j]) begin
      set_wr(1, 0, 3'(fill_idx[j]), 20'h40000 + 20'(fill_idx[j]), 8'h00, 0);
      cyc("fill", 0, mk(0, 0, 0, r0, 3'(fill_idx[j]), 1, 0), MM);
    end
    set_wr(1, 0, 1, 20'h55555, 8'h00, 0); inv_all = 1'b1; look(20'h40004, 8'h00);
    cyc("inv_beats_wr", 0, mk(1, 4, 0, r0, 4, 0, 0), MM);
    for (int k = 0; k < 8; k++) begin
      inv_all = (k == 3);
      cyc("sweep", 0, mk(0, 0, 1, r0, 3'(k), 1, 1), MM);
    end
    inv_all = 1'b0; set_wr(0, 0, 0, 20'h0, 8'h0, 0);
    cyc("post_40004", 0, mk(0, 0, 0, r0, 0, 0, 0), MM);
    look(20'h55555, 8'h00);
    cyc("post_dropped", 0, mk(0, 0, 0, r0, 0, 0, 0), MM);
    look(20'h0ABCD, 8'h77);
    cyc("post_glob", 0, mk(0, 0, 0, r0, 0, 0, 0), MM);
    look(20'h11111, 8'h05);
    cyc("post_11111", 0, mk(0, 0, 0, r0, 0, 0, 0), MM);
    look(20'h00002, 8'h01);
    cyc("post_00002", 0, mk(0, 0, 0, r0, 0, 0, 0), MM);
    set_wr(1, 0, 1, 20'h0BEEF, 8'h02, 0); look(20'h0, 8'h0);
    cyc("w4_idx1", 1, mk(0, 0, 0, r4, 1, 1, 0), MM);
    look(20'h0BEEF, 8'h02);
    for (int k = 0; k < 20; k++) begin
      set_wr(1, 1, 0, 20'h60000 + 20'(k), 8'h00, 0);
      last_t = r4;
      cyc("w4_rand", 1, mk(1, 1, 0, r4, r4, 1, 0), MM);
    end
    set_wr(0, 0, 0, 20'h0, 8'h0, 0);
    cyc("w4_survive", 1, mk(1, 1, 0, r4, 1, 0, 0), MM);
    look(20'h60013, 8'h00);
    cyc("w4_last", 1, mk(1, last_t, 0, r4, last_t, 0, 0), MM);
    @(negedge clk);
    #1;
    if (total < 12) $display("FAIL check_count: got %0d expected at least 12", total);
    if (passed != total) $display("FAIL summary: got %0d passed expected %0d", passed, total);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
